boot_image_loader: RTL and testbench

Program loader sitting directly upstream of the core's instruction/data `SyncRam` and of the core's `PowerOn` input. It accepts a byte stream over a valid/ready handshake, packs the bytes into 16-bit words and writes them into RAM starting at `BASE_ADDR`. It holds the core in reset until the image is written, then releases it. This replaces in-place RAM initialisation with a synthesizable boot path.

---
 rtl/boot_image_loader_pkg.sv | 24 ++
 rtl/boot_image_loader_if.sv | 23 ++
 rtl/boot_image_loader_word_packer.sv | 32 +++
 rtl/boot_image_loader.sv | 146 ++++++++++++++
 tb/tb_boot_image_loader.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/boot_image_loader_pkg.sv
// Shared state encoding and byte width for the boot image loader.
// Optional checksum trailer is enabled by defining BOOT_CHECKSUM_EN (undefined by default).
package boot_image_loader_pkg;

    localparam int BOOT_BYTE_WIDTH = 8;

    typedef enum logic [3:0] {
        S_LEN_HI  = 4'd0,
        S_LEN_LO  = 4'd1,
        S_DAT_HI  = 4'd2,
        S_DAT_LO  = 4'd3,
        S_CHK_HI  = 4'd4,
        S_CHK_LO  = 4'd5,
        S_RELEASE = 4'd6,
        S_RUN     = 4'd7,
        S_ERROR   = 4'd8
    } boot_state_t;

    function automatic logic state_takes_input(input boot_state_t s);
        return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DAT_HI) ||
               (s == S_DAT_LO) || (s == S_CHK_HI) || (s == S_CHK_LO);
    endfunction

endpackage

// File: rtl/boot_image_loader_if.sv
// Byte-stream input and RAM write port of the boot loader.
// master = loader side, slave = stream source / RAM side.
interface boot_image_loader_if #(
    parameter int WORD_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic [7:0]            InByte;
    logic                  InValid;
    logic                  InReady;
    logic                  RamWriteEnable;
    logic [ADDR_WIDTH-1:0] RamWriteAddr;
    logic [WORD_WIDTH-1:0] RamWriteData;

    modport master (
        input  InByte, InValid,
        output InReady, RamWriteEnable, RamWriteAddr, RamWriteData
    );

    modport slave (
        output InByte, InValid,
        input  InReady, RamWriteEnable, RamWriteAddr, RamWriteData
    );
endinterface

// File: rtl/boot_image_loader_word_packer.sv
// Latches the high byte, registers {hi,lo} on the low byte and raises a one-cycle write strobe.
// Latency: strobe and data appear one cycle after lo_take; no backpressure (follows the FSM).
module boot_word_packer
    import boot_image_loader_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          hi_take,
    input  logic                          lo_take,
    input  logic [BOOT_BYTE_WIDTH-1:0]    byte_in,
    output logic [BOOT_BYTE_WIDTH-1:0]    hi_byte,
    output logic                          write_en,
    output logic [2*BOOT_BYTE_WIDTH-1:0]  write_data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_byte    <= '0;
            write_en   <= 1'b0;
            write_data <= '0;
        end else begin
            write_en <= lo_take;
            if (hi_take) begin
                hi_byte <= byte_in;
            end
            if (lo_take) begin
                write_data <= {hi_byte, byte_in};
            end
        end
    end

endmodule

// File: rtl/boot_image_loader.sv
// Boot loader: unpacks a length-prefixed byte stream into RAM words, then releases the core.
// Optional XOR checksum trailer when BOOT_CHECKSUM_EN is defined; InReady is registered from state.
module boot_image_loader
    import boot_image_loader_pkg::*;
#(
    parameter int          WORD_WIDTH = 16,
    parameter int          ADDR_WIDTH = 16,
    parameter int unsigned BASE_ADDR  = 0
)
(
    input  logic                  gclk,
    input  logic                  PowerOn,
    boot_image_loader_if.master   bus,
    output logic                  CoreReset,
    output logic                  Done,
    output logic                  Error,
    output logic [ADDR_WIDTH-1:0] WordCount
);

    localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
    // Largest image that fits between BASE and the top of the address space.
    localparam logic [32:0]           LIMIT = (33'd1 << ADDR_WIDTH) - 33'(BASE_ADDR);

    boot_state_t state_q, state_d;
    logic        ready_q;
    logic        accept;
    logic        hi_take, lo_take;
    logic [7:0]  hi_byte;
    logic        pk_we;
    logic [15:0] pk_data;
    logic [15:0] len_q;
    logic [15:0] byte_pair;
    logic        last_word;
`ifdef BOOT_CHECKSUM_EN
    logic [15:0] csum_q;
`endif

    assign accept    = bus.InValid && ready_q;
    assign byte_pair = {hi_byte, bus.InByte};
    assign last_word = (33'(WordCount) + 33'd1) == 33'(len_q);

    boot_word_packer u_packer (
        .clk        (gclk),
        .rst        (PowerOn),
        .hi_take    (hi_take),
        .lo_take    (lo_take),
        .byte_in    (bus.InByte),
        .hi_byte    (hi_byte),
        .write_en   (pk_we),
        .write_data (pk_data)
    );

    always_comb begin
        state_d = state_q;
        hi_take = 1'b0;
        lo_take = 1'b0;
        case (state_q)
            S_LEN_HI: if (accept) begin
                hi_take = 1'b1;
                state_d = S_LEN_LO;
            end
            S_LEN_LO: if (accept) begin
                if (33'(byte_pair) > LIMIT) begin
                    state_d = S_ERROR;
                end else if (byte_pair == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
                    state_d = S_CHK_HI;
`else
                    state_d = S_RELEASE;
`endif
                end else begin
                    state_d = S_DAT_HI;
                end
            end
            S_DAT_HI: if (accept) begin
                hi_take = 1'b1;
                state_d = S_DAT_LO;
            end
            S_DAT_LO: if (accept) begin
                lo_take = 1'b1;
                if (last_word) begin
`ifdef BOOT_CHECKSUM_EN
                    state_d = S_CHK_HI;
`else
                    state_d = S_RELEASE;
`endif
                end else begin
                    state_d = S_DAT_HI;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            S_CHK_HI: if (accept) begin
                hi_take = 1'b1;
                state_d = S_CHK_LO;
            end
            S_CHK_LO: if (accept) begin
                state_d = (byte_pair == csum_q) ? S_RELEASE : S_ERROR;
            end
`endif
            S_RELEASE: state_d = S_RUN;
            S_RUN:     state_d = S_RUN;
            S_ERROR:   state_d = S_ERROR;
            default:   state_d = S_ERROR;
        endcase
    end

    always_ff @(posedge gclk) begin
        if (PowerOn) begin
            state_q   <= S_LEN_HI;
            ready_q   <= 1'b0;
            len_q     <= '0;
            WordCount <= '0;
            CoreReset <= 1'b1;
            Done      <= 1'b0;
            Error     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= state_takes_input(state_d);
            CoreReset <= (state_d != S_RUN);
            Done      <= (state_d == S_RUN);
            Error     <= (state_d == S_ERROR);
            if (state_q == S_LEN_LO && accept) begin
                len_q <= byte_pair;
            end
            if (pk_we) begin
                WordCount <= WordCount + 1'b1;
            end
        end
    end

`ifdef BOOT_CHECKSUM_EN
    always_ff @(posedge gclk) begin
        if (PowerOn) begin
            csum_q <= '0;
        end else if (lo_take) begin
            csum_q <= csum_q ^ byte_pair;
        end
    end
`endif

    assign bus.InReady        = ready_q;
    assign bus.RamWriteEnable = pk_we;
    assign bus.RamWriteAddr   = BASE + WordCount;
    assign bus.RamWriteData   = WORD_WIDTH'(pk_data);

endmodule

// File: tb/tb_boot_image_loader.sv
// Directed bench: dut0 at BASE_ADDR 0, dut1 at BASE_ADDR FFFE for the length-limit and top-of-memory cases.
module tb_boot_image_loader;

    typedef logic [7:0] bq_t[$];

    logic gclk = 1'b0;
    logic pon0 = 1'b1;
    logic pon1 = 1'b1;
    logic core_reset0, done0, error0;
    logic core_reset1, done1, error1;
    logic [15:0] wc0, wc1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] ram0 [logic [15:0]];
    logic [15:0] ram1 [logic [15:0]];
    int n_str0 = 0, n_str1 = 0;
    int last_str0 = -1;
    int done_cyc0 = -1;
    int acc_q[$];

    always #5 gclk = ~gclk;
    always @(posedge gclk) cyc++;

    boot_image_loader_if #(.WORD_WIDTH(16), .ADDR_WIDTH(16)) bus0 ();
    boot_image_loader_if #(.WORD_WIDTH(16), .ADDR_WIDTH(16)) bus1 ();

    boot_image_loader #(.WORD_WIDTH(16), .ADDR_WIDTH(16), .BASE_ADDR(0)) dut0 (
        .gclk(gclk), .PowerOn(pon0), .bus(bus0),
        .CoreReset(core_reset0), .Done(done0), .Error(error0), .WordCount(wc0)
    );

    boot_image_loader #(.WORD_WIDTH(16), .ADDR_WIDTH(16), .BASE_ADDR(32'hFFFE)) dut1 (
        .gclk(gclk), .PowerOn(pon1), .bus(bus1),
        .CoreReset(core_reset1), .Done(done1), .Error(error1), .WordCount(wc1)
    );

    // RAM and timing model, sampled on the falling edge.
    always @(negedge gclk) begin
        if (bus0.RamWriteEnable === 1'b1) begin
            ram0[bus0.RamWriteAddr] = bus0.RamWriteData;
            n_str0++;
            last_str0 = cyc;
        end
        if (done0 === 1'b1 && done_cyc0 < 0) done_cyc0 = cyc;
        if (bus1.RamWriteEnable === 1'b1) begin
            ram1[bus1.RamWriteAddr] = bus1.RamWriteData;
            n_str1++;
        end
    end

    function automatic logic rdy(input int sel);
        return (sel == 0) ? bus0.InReady : bus1.InReady;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [7:0] b);
        if (sel == 0) begin bus0.InValid = v; bus0.InByte = b; end
        else          begin bus1.InValid = v; bus1.InByte = b; end
    endtask

    task automatic send(input int sel, input logic [7:0] b);
        int t = 0;
        while (rdy(sel) !== 1'b1 && t < 20) begin
            @(negedge gclk);
            t++;
        end
        checks++;
        if (rdy(sel) !== 1'b1) begin
            errors++;
            $display("FAIL send_ready dut%0d: InReady=%b required 1", sel, rdy(sel));
        end else begin
            drive(sel, 1'b1, b);
            acc_q.push_back(cyc);
            @(negedge gclk);
            drive(sel, 1'b0, 8'h00);
        end
    endtask

    task automatic stream(input int sel, input bq_t q, input int gap);
        acc_q.delete();
        foreach (q[i]) begin
            send(sel, q[i]);
            repeat (gap) @(negedge gclk);
        end
    endtask

    // Leaves the bench at a falling edge with the selected DUT out of reset and its model cleared.
    task automatic do_reset(input int sel);
        if (sel == 0) pon0 = 1'b1; else pon1 = 1'b1;
        @(negedge gclk);
        @(posedge gclk);
        #1;
        if (sel == 0) begin
            ram0.delete(); n_str0 = 0; last_str0 = -1; done_cyc0 = -1;
        end else begin
            ram1.delete(); n_str1 = 0;
        end
        @(negedge gclk);
        if (sel == 0) pon0 = 1'b0; else pon1 = 1'b0;
        @(negedge gclk);
    endtask

    task automatic test_reset;
        pon0 = 1'b1;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        repeat (3) @(negedge gclk);
        checks++; if (bus0.InReady !== 1'b0) begin errors++; $display("FAIL rst_inready: got %b want 0", bus0.InReady); end
        checks++; if (bus0.RamWriteEnable !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", bus0.RamWriteEnable); end
        checks++; if (bus0.RamWriteAddr !== 16'h0000) begin errors++; $display("FAIL rst_addr: got %h want 0000", bus0.RamWriteAddr); end
        checks++; if (bus1.RamWriteAddr !== 16'hFFFE) begin errors++; $display("FAIL rst_addr1: got %h want fffe", bus1.RamWriteAddr); end
        checks++; if (bus0.RamWriteData !== 16'h0000) begin errors++; $display("FAIL rst_data: got %h want 0000", bus0.RamWriteData); end
        checks++; if (core_reset0 !== 1'b1) begin errors++; $display("FAIL rst_corereset: got %b want 1", core_reset0); end
        checks++; if (done0 !== 1'b0 || error0 !== 1'b0) begin errors++; $display("FAIL rst_done_err: got %b%b want 00", done0, error0); end
        checks++; if (wc0 !== 16'h0000) begin errors++; $display("FAIL rst_wordcount: got %h want 0000", wc0); end
        pon0 = 1'b0;
        @(posedge gclk);
        #1;
        checks++; if (bus0.InReady !== 1'b1) begin errors++; $display("FAIL rst_ready_rise: got %b want 1", bus0.InReady); end
    endtask

    task automatic check_basic(input string tag, input logic [15:0] w0, input logic [15:0] w1);
        repeat (4) @(negedge gclk);
        checks++; if (ram0[16'h0000] !== w0) begin errors++; $display("FAIL %s_ram0: got %h want %h", tag, ram0[16'h0000], w0); end
        checks++; if (ram0[16'h0001] !== w1) begin errors++; $display("FAIL %s_ram1: got %h want %h", tag, ram0[16'h0001], w1); end
        checks++; if (n_str0 !== 2) begin errors++; $display("FAIL %s_strobes: got %0d want 2", tag, n_str0); end
        checks++; if (wc0 !== 16'd2) begin errors++; $display("FAIL %s_wordcount: got %0d want 2", tag, wc0); end
        checks++; if (last_str0 !== acc_q[5] + 1) begin errors++; $display("FAIL %s_write_latency: got cycle %0d want %0d", tag, last_str0, acc_q[5] + 1); end
        checks++; if (done_cyc0 !== acc_q[acc_q.size()-1] + 2) begin errors++; $display("FAIL %s_done_time: got cycle %0d want %0d", tag, done_cyc0, acc_q[acc_q.size()-1] + 2); end
        checks++; if (done0 !== 1'b1 || core_reset0 !== 1'b0 || error0 !== 1'b0) begin errors++; $display("FAIL %s_run: done=%b corereset=%b error=%b want 1 0 0", tag, done0, core_reset0, error0); end
        checks++; if (bus0.InReady !== 1'b0) begin errors++; $display("FAIL %s_ready_run: got %b want 0", tag, bus0.InReady); end
    endtask

    task automatic test_back_to_back;
        bq_t q;
        q = '{8'h00, 8'h02, 8'h00, 8'hC2, 8'h00, 8'h01};
`ifdef BOOT_CHECKSUM_EN
        q.push_back(8'h00); q.push_back(8'hC3);
`endif
        do_reset(0);
        stream(0, q, 0);
        checks++; if (acc_q[5] - acc_q[0] !== 5) begin errors++; $display("FAIL b2b_throughput: got %0d cycles want 5", acc_q[5] - acc_q[0]); end
        check_basic("b2b", 16'h00C2, 16'h0001);
    endtask

    task automatic test_gaps;
        bq_t q;
        q = '{8'h00, 8'h02, 8'h00, 8'hC2, 8'h00, 8'h01};
`ifdef BOOT_CHECKSUM_EN
        q.push_back(8'h00); q.push_back(8'hC3);
`endif
        do_reset(0);
        stream(0, q, 1);
        check_basic("gaps", 16'h00C2, 16'h0001);
    endtask

    task automatic test_len_zero;
        bq_t q;
        q = '{8'h00, 8'h00};
`ifdef BOOT_CHECKSUM_EN
        q.push_back(8'h00); q.push_back(8'h00);
`endif
        do_reset(0);
        stream(0, q, 0);
        repeat (4) @(negedge gclk);
        checks++; if (n_str0 !== 0) begin errors++; $display("FAIL len0_strobes: got %0d want 0", n_str0); end
        checks++; if (done_cyc0 !== acc_q[acc_q.size()-1] + 2) begin errors++; $display("FAIL len0_done_time: got cycle %0d want %0d", done_cyc0, acc_q[acc_q.size()-1] + 2); end
        checks++; if (wc0 !== 16'd0 || core_reset0 !== 1'b0) begin errors++; $display("FAIL len0_state: wordcount=%0d corereset=%b want 0 0", wc0, core_reset0); end
    endtask

    task automatic test_len_limit;
        bq_t q;
        do_reset(1);
        q = '{8'h00, 8'h03};
        stream(1, q, 0);
        drive(1, 1'b1, 8'h55);
        repeat (4) @(negedge gclk);
        drive(1, 1'b0, 8'h00);
        checks++; if (error1 !== 1'b1) begin errors++; $display("FAIL limit_error: got %b want 1", error1); end
        checks++; if (bus1.InReady !== 1'b0) begin errors++; $display("FAIL limit_ready: got %b want 0", bus1.InReady); end
        checks++; if (core_reset1 !== 1'b1 || done1 !== 1'b0) begin errors++; $display("FAIL limit_core: corereset=%b done=%b want 1 0", core_reset1, done1); end
        checks++; if (n_str1 !== 0) begin errors++; $display("FAIL limit_strobes: got %0d want 0", n_str1); end
        // LEN=2 exactly fills FFFE..FFFF.
        do_reset(1);
        q = '{8'h00, 8'h02, 8'hAB, 8'hCD, 8'h12, 8'h34};
`ifdef BOOT_CHECKSUM_EN
        q.push_back(8'hB9); q.push_back(8'hF9);
`endif
        stream(1, q, 0);
        repeat (4) @(negedge gclk);
        checks++; if (ram1[16'hFFFE] !== 16'hABCD) begin errors++; $display("FAIL top_ram_fffe: got %h want abcd", ram1[16'hFFFE]); end
        checks++; if (ram1[16'hFFFF] !== 16'h1234) begin errors++; $display("FAIL top_ram_ffff: got %h want 1234", ram1[16'hFFFF]); end
        checks++; if (done1 !== 1'b1 || error1 !== 1'b0 || wc1 !== 16'd2) begin errors++; $display("FAIL top_run: done=%b error=%b wordcount=%0d want 1 0 2", done1, error1, wc1); end
    endtask

`ifdef BOOT_CHECKSUM_EN
    task automatic test_checksum;
        bq_t q;
        do_reset(0);
        q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h00, 8'hFF, 8'h12, 8'hCB};
        stream(0, q, 0);
        repeat (4) @(negedge gclk);
        checks++; if (done0 !== 1'b1 || error0 !== 1'b0) begin errors++; $display("FAIL chk_good: done=%b error=%b want 1 0", done0, error0); end
        do_reset(0);
        q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h00, 8'hFF, 8'h12, 8'hCA};
        stream(0, q, 0);
        repeat (4) @(negedge gclk);
        checks++; if (done0 !== 1'b0 || error0 !== 1'b1 || core_reset0 !== 1'b1) begin errors++; $display("FAIL chk_bad: done=%b error=%b corereset=%b want 0 1 1", done0, error0, core_reset0); end
    endtask
`endif

    task automatic test_poweron_mid;
        bq_t q;
        do_reset(0);
        q = '{8'h00, 8'h02, 8'h00, 8'hC2, 8'h00};
        stream(0, q, 0);
        pon0 = 1'b1;
        @(posedge gclk);
        #1;
        checks++; if (bus0.InReady !== 1'b0 || bus0.RamWriteEnable !== 1'b0) begin errors++; $display("FAIL mid_ready_we: ready=%b we=%b want 0 0", bus0.InReady, bus0.RamWriteEnable); end
        checks++; if (wc0 !== 16'd0 || bus0.RamWriteAddr !== 16'h0000 || bus0.RamWriteData !== 16'h0000) begin errors++; $display("FAIL mid_regs: wordcount=%0d addr=%h data=%h want 0 0000 0000", wc0, bus0.RamWriteAddr, bus0.RamWriteData); end
        checks++; if (core_reset0 !== 1'b1 || done0 !== 1'b0 || error0 !== 1'b0) begin errors++; $display("FAIL mid_status: corereset=%b done=%b error=%b want 1 0 0", core_reset0, done0, error0); end
        n_str0 = 0; done_cyc0 = -1; last_str0 = -1;
        @(negedge gclk);
        pon0 = 1'b0;
        @(negedge gclk);
        q = '{8'h00, 8'h02, 8'hBE, 8'hEF, 8'hCA, 8'hFE};
`ifdef BOOT_CHECKSUM_EN
        q.push_back(8'h74); q.push_back(8'h11);
`endif
        stream(0, q, 0);
        check_basic("reload", 16'hBEEF, 16'hCAFE);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_len_zero();
        test_len_limit();
`ifdef BOOT_CHECKSUM_EN
        test_checksum();
`endif
        test_poweron_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
